mul_issue_ctrl: RTL and testbench

- Front-end controller for the 2-cycle pipelined booth/wallace multiplier.
- Arbitrates between two reservation-station issue ports and drives the multiplier's operand/opcode inputs.
- Tracks each in-flight operation's tag and opcode down the fixed pipeline, selects the low or high result word, and queues results for the writeback/CDB port behind a valid/ready handshake.
- Credit-based issue guarantees the non-stallable multiplier never overflows the result queue.

---
 rtl/mul_issue_ctrl.sv | 158 +++++++++++++++
 tb/tb_mul_issue_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_ctrl.sv
// rtl/mul_issue_ctrl.sv - issue arbiter, tag tracker and result queue for a fixed-latency multiplier
// Credit-based issue keeps in-flight plus queued operations within the result queue depth.
module mul_issue_ctrl #(
  parameter int WORD_WIDTH  = 32,
  parameter int TAG_WIDTH   = 6,
  parameter int MUL_LATENCY = 2,
  parameter int OUT_DEPTH   = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_flush,
  input  logic                      i_req0_valid,
  input  logic                      i_req1_valid,
  output logic                      o_req0_ready,
  output logic                      o_req1_ready,
  input  logic [2:0]                i_req0_opcode,
  input  logic [2:0]                i_req1_opcode,
  input  logic [WORD_WIDTH-1:0]     i_req0_data1,
  input  logic [WORD_WIDTH-1:0]     i_req0_data2,
  input  logic [WORD_WIDTH-1:0]     i_req1_data1,
  input  logic [WORD_WIDTH-1:0]     i_req1_data2,
  input  logic [TAG_WIDTH-1:0]      i_req0_tag,
  input  logic [TAG_WIDTH-1:0]      i_req1_tag,
  output logic                      o_mul_en,
  output logic [2:0]                o_mul_opcode,
  output logic [WORD_WIDTH-1:0]     o_mul_data1,
  output logic [WORD_WIDTH-1:0]     o_mul_data2,
  input  logic [2*WORD_WIDTH+1:0]   i_mul_result,
  input  logic                      i_mul_result_valid,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [WORD_WIDTH-1:0]     o_out_data,
  output logic [TAG_WIDTH-1:0]      o_out_tag,
  output logic                      o_busy
);
  localparam int QPW = $clog2(OUT_DEPTH);
  localparam int QCW = $clog2(OUT_DEPTH + 1);
  localparam int CW  = $clog2(OUT_DEPTH + MUL_LATENCY + 1);
  localparam int LST = MUL_LATENCY - 1;

  logic [MUL_LATENCY-1:0] r_vld;
  logic [MUL_LATENCY-1:0] r_hi;
  logic [TAG_WIDTH-1:0]   r_tag [MUL_LATENCY];
  logic                   r_rr;
  logic [WORD_WIDTH-1:0]  r_q_data [OUT_DEPTH];
  logic [TAG_WIDTH-1:0]   r_q_tag  [OUT_DEPTH];
  logic [QPW-1:0]         r_wr_ptr;
  logic [QPW-1:0]         r_rd_ptr;
  logic [QCW-1:0]         r_q_count;

  logic [CW-1:0]          w_inflight;
  logic                   w_can_issue;
  logic                   w_grant0;
  logic                   w_grant1;
  logic                   w_issue;
  logic                   w_sel_hi;
  logic [TAG_WIDTH-1:0]   w_tag;
  logic                   w_push;
  logic                   w_pop;
  logic [WORD_WIDTH-1:0]  w_push_data;
  logic                   w_unused_ext;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < MUL_LATENCY; i++) w_inflight = w_inflight + CW'(r_vld[i]);
  end

  // A same-cycle pop is not credited: r_q_count is the registered occupancy.
  assign w_can_issue = ((CW'(r_q_count) + w_inflight) < CW'(OUT_DEPTH)) && !i_flush && !i_rst;
  assign w_grant0    = w_can_issue && i_req0_valid && (!i_req1_valid || !r_rr);
  assign w_grant1    = w_can_issue && i_req1_valid && (!i_req0_valid ||  r_rr);
  assign w_issue     = w_grant0 || w_grant1;

  assign o_req0_ready = w_grant0;
  assign o_req1_ready = w_grant1;
  assign o_mul_en     = w_issue;

  always_comb begin
    o_mul_opcode = '0;
    o_mul_data1  = '0;
    o_mul_data2  = '0;
    w_tag        = '0;
    if (w_grant0) begin
      o_mul_opcode = i_req0_opcode;
      o_mul_data1  = i_req0_data1;
      o_mul_data2  = i_req0_data2;
      w_tag        = i_req0_tag;
    end else if (w_grant1) begin
      o_mul_opcode = i_req1_opcode;
      o_mul_data1  = i_req1_data1;
      o_mul_data2  = i_req1_data2;
      w_tag        = i_req1_tag;
    end
  end

  assign w_sel_hi = (o_mul_opcode != 3'b000);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_rr <= 1'b0;
    else if (w_grant0) r_rr <= 1'b1;
    else if (w_grant1) r_rr <= 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_issue;
      for (int i = 1; i < MUL_LATENCY; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  always_ff @(posedge i_clk) begin
    r_tag[0] <= w_tag;
    r_hi[0]  <= w_sel_hi;
    for (int i = 1; i < MUL_LATENCY; i++) begin
      r_tag[i] <= r_tag[i-1];
      r_hi[i]  <= r_hi[i-1];
    end
  end

  assign w_push       = r_vld[LST] && i_mul_result_valid && !i_flush;
  assign w_pop        = o_out_valid && i_out_ready;
  assign w_push_data  = r_hi[LST] ? i_mul_result[2*WORD_WIDTH-1:WORD_WIDTH]
                                  : i_mul_result[WORD_WIDTH-1:0];
  // The two extension bits of the product never reach the writeback word.
  assign w_unused_ext = ^i_mul_result[2*WORD_WIDTH+1:2*WORD_WIDTH];

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_q_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_q_count <= r_q_count + 1'b1;
      else if (!w_push && w_pop) r_q_count <= r_q_count - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q_data[r_wr_ptr] <= w_push_data;
      r_q_tag[r_wr_ptr]  <= r_tag[LST];
    end
  end

  assign o_out_valid = (r_q_count != '0) && !i_rst;
  assign o_out_data  = r_q_data[r_rd_ptr];
  assign o_out_tag   = r_q_tag[r_rd_ptr];
  assign o_busy      = ((w_inflight != '0) || (r_q_count != '0)) && !i_rst;

  a_result_present: assert property (@(posedge i_clk) disable iff (i_rst)
    (r_vld[LST] && !i_flush) |-> i_mul_result_valid);
  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    w_push |-> (r_q_count != QCW'(OUT_DEPTH)));
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb/tb_mul_issue_ctrl.sv - directed and randomized bench for mul_issue_ctrl against a transaction-level model
module tb_mul_issue_ctrl;
  localparam int W     = 32;
  localparam int TW    = 6;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0]    req0_opcode, req1_opcode;
  logic [W-1:0]  req0_data1, req0_data2, req1_data1, req1_data2;
  logic [TW-1:0] req0_tag, req1_tag;
  logic          mul_en;
  logic [2:0]    mul_opcode;
  logic [W-1:0]  mul_data1, mul_data2;
  logic [2*W+1:0] mul_result;
  logic          mul_result_valid;
  logic          out_valid, out_ready, busy;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;

  mul_issue_ctrl #(.WORD_WIDTH(W), .TAG_WIDTH(TW), .MUL_LATENCY(LAT), .OUT_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_req0_valid(req0_valid), .i_req1_valid(req1_valid),
    .o_req0_ready(req0_ready), .o_req1_ready(req1_ready),
    .i_req0_opcode(req0_opcode), .i_req1_opcode(req1_opcode),
    .i_req0_data1(req0_data1), .i_req0_data2(req0_data2),
    .i_req1_data1(req1_data1), .i_req1_data2(req1_data2),
    .i_req0_tag(req0_tag), .i_req1_tag(req1_tag),
    .o_mul_en(mul_en), .o_mul_opcode(mul_opcode),
    .o_mul_data1(mul_data1), .o_mul_data2(mul_data2),
    .i_mul_result(mul_result), .i_mul_result_valid(mul_result_valid),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_data(out_data), .o_out_tag(out_tag), .o_busy(busy)
  );

  typedef struct {
    logic [W-1:0]  data;
    logic [TW-1:0] tag;
    int            rdy;
  } exp_t;

  exp_t           eq[$];
  logic           rr_m;
  int             cyc;
  int             n_cmp;
  int             n_fail;
  logic [1:0]     pv;
  logic [2*W+1:0] pr [2];

  // Expected writeback word from RISC-V multiply semantics on 64-bit integers.
  function automatic logic [W-1:0] ref_word(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint     sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (op)
      3'd0:    p = 64'(sa * sb);
      3'd1:    p = 64'(sa * sb);
      3'd2:    p = 64'(sa * ub);
      default: p = 64'(ua * ub);
    endcase
    return (op == 3'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [2*W+1:0] env_mul(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W+1:0] xa, xb;
    xa = (op == 3'd3) ? {34'd0, a} : {{34{a[31]}}, a};
    xb = (op == 3'd2 || op == 3'd3) ? {34'd0, b} : {{34{b[31]}}, b};
    return xa * xb;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", name, obs, exp, cyc);
    end
  endtask

  task automatic step(input logic v0, input logic [2:0] op0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                      input logic [TW-1:0] t0,
                      input logic v1, input logic [2:0] op1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                      input logic [TW-1:0] t1,
                      input logic ordy, input logic fl, input logic rs);
    logic can, eg0, eg1, ev;
    exp_t e;
    @(negedge clk);
    rst = rs; flush = fl; out_ready = ordy;
    req0_valid = v0; req0_opcode = op0; req0_data1 = a0; req0_data2 = b0; req0_tag = t0;
    req1_valid = v1; req1_opcode = op1; req1_data1 = a1; req1_data2 = b1; req1_tag = t1;
    #1;
    can = (eq.size() < DEPTH) && !fl && !rs;
    eg0 = can && v0 && (!v1 || !rr_m);
    eg1 = can && v1 && (!v0 || rr_m);
    chk("req0_ready", 64'(req0_ready), 64'(eg0));
    chk("req1_ready", 64'(req1_ready), 64'(eg1));
    chk("mul_en", 64'(mul_en), 64'(eg0 | eg1));
    if (eg0) begin
      chk("mul_opcode", 64'(mul_opcode), 64'(op0));
      chk("mul_data1", 64'(mul_data1), 64'(a0));
      chk("mul_data2", 64'(mul_data2), 64'(b0));
    end else if (eg1) begin
      chk("mul_opcode", 64'(mul_opcode), 64'(op1));
      chk("mul_data1", 64'(mul_data1), 64'(a1));
      chk("mul_data2", 64'(mul_data2), 64'(b1));
    end else begin
      chk("mul_idle_data", 64'(mul_data1), 64'd0);
    end
    ev = 1'b0;
    if (!rs && eq.size() != 0) ev = (eq[0].rdy <= cyc);
    chk("out_valid", 64'(out_valid), 64'(ev));
    if (ev) begin
      chk("out_data", 64'(out_data), 64'(eq[0].data));
      chk("out_tag", 64'(out_tag), 64'(eq[0].tag));
    end
    chk("busy", 64'(busy), 64'(!rs && eq.size() != 0));
    // Environment multiplier: fixed two-cycle pipeline, never stalls.
    mul_result_valid = pv[1];
    mul_result       = pr[1];
    pv[1] = pv[0];
    pr[1] = pr[0];
    pv[0] = mul_en;
    pr[0] = env_mul(mul_opcode, mul_data1, mul_data2);
    if (rs) begin
      eq.delete();
      rr_m = 1'b0;
    end else if (fl) begin
      eq.delete();
    end else begin
      if (ev && ordy) void'(eq.pop_front());
      if (eg0) begin
        e.data = ref_word(op0, a0, b0); e.tag = t0; e.rdy = cyc + LAT + 1;
        eq.push_back(e);
        rr_m = 1'b1;
      end else if (eg1) begin
        e.data = ref_word(op1, a1, b1); e.tag = t1; e.rdy = cyc + LAT + 1;
        eq.push_back(e);
        rr_m = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step('0, '0, '0, '0, '0, '0, '0, '0, '0, '0, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    req0_valid = 1'b0; req0_opcode = '0; req0_data1 = '0; req0_data2 = '0; req0_tag = '0;
    req1_valid = 1'b0; req1_opcode = '0; req1_data1 = '0; req1_data2 = '0; req1_tag = '0;
    mul_result = '0; mul_result_valid = 1'b0;
    pv = '0; pr[0] = '0; pr[1] = '0;
    rr_m = 1'b0; cyc = 0; n_cmp = 0; n_fail = 0;

    for (int i = 0; i < 2; i++) step('0, '0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b1);

    // single MUL, then high-word ops
    step(1'b1, 3'd0, 32'd7, 32'd6, 6'd5, 1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b1);
    step(1'b0, '0, '0, '0, '0, 1'b1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd9, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3, 6'd10, 1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b1);

    // round-robin with both requesters valid
    for (int i = 0; i < 6; i++)
      step(1'b1, 3'($urandom_range(0, 3)), 32'($urandom), 32'($urandom), 6'(i),
           1'b1, 3'($urandom_range(0, 3)), 32'($urandom), 32'($urandom), 6'(16 + i), 1'b1, 1'b0, 1'b0);
    idle(5, 1'b1);

    // backpressure: fill the credit, then drain while streaming
    for (int i = 0; i < 8; i++)
      step(1'b1, 3'($urandom_range(0, 3)), 32'($urandom), 32'($urandom), 6'(32 + i),
           1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      step(1'b1, 3'($urandom_range(0, 3)), 32'($urandom), 32'($urandom), 6'(48 + i),
           1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    idle(6, 1'b1);

    // flush on the capture cycle of the first op
    step(1'b1, 3'd0, 32'd3, 32'd4, 6'd20, 1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd2, 32'd5, 32'd6, 6'd21, 1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd0, 32'd8, 32'd9, 6'd22, 1'b0, '0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 3'd0, 32'd8, 32'd9, 6'd22, 1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    idle(5, 1'b1);

    // reset with work tracked and queued
    for (int i = 0; i < 3; i++)
      step(1'b1, 3'd0, 32'($urandom), 32'($urandom), 6'(24 + i), 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd0, '0, '0, '0, 1'b1, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'd1, 32'($urandom), 32'($urandom), 6'd30, 1'b1, 3'd3, 32'($urandom), 32'($urandom), 6'd31,
         1'b1, 1'b0, 1'b0);
    idle(6, 1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), 32'($urandom), 32'($urandom), 6'($urandom),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), 32'($urandom), 32'($urandom), 6'($urandom),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 99) == 0));
    idle(8, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
